// File: rtl/cobra_exec_ctrl_if.sv
// Board-debug / core-side signal bundle for cobra_exec_ctrl.
// The slave modport is the sequencer; the master modport is whatever drives it.
interface cobra_exec_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run_i;
  logic             halt_i;
  logic             step_i;
  logic             bp_en_i;
  logic [31:0]      bp_addr_i;
  logic [31:0]      pc_i;
  logic [31:0]      instr_i;
  logic             sw_valid_i;
  logic             core_en_o;
  logic             sw_ack_o;
  logic [2:0]       state_o;
  logic             halted_o;
  logic [CNT_W-1:0] retired_o;
  logic             wdt_o;

  modport master (
    output run_i, halt_i, step_i, bp_en_i, bp_addr_i, pc_i, instr_i, sw_valid_i,
    input  core_en_o, sw_ack_o, state_o, halted_o, retired_o, wdt_o
  );

  modport slave (
    input  run_i, halt_i, step_i, bp_en_i, bp_addr_i, pc_i, instr_i, sw_valid_i,
    output core_en_o, sw_ack_o, state_o, halted_o, retired_o, wdt_o
  );
endinterface

// File: rtl/cobra_exec_ctrl.sv
// Run/halt/single-step sequencer for CYBERcobra with PC breakpoint and switch-wait stall.
// Optional WAIT_SW watchdog is enabled by defining COBRA_EXEC_CTRL_WDT_EN.
module cobra_exec_ctrl #(
  parameter int CNT_W      = 32,
  parameter int WDT_CYCLES = 1000
) (
  input logic             clk_i,
  input logic             rst_i,
  cobra_exec_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    STEP    = 3'd2,
    WAIT_SW = 3'd3,
    BREAK   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             step_mode_q, step_mode_d;
  logic             bp_skip_q, bp_skip_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             commit, ack;
  logic             sw_instr, bp_hit;
  logic             unused_instr_bits;

  assign sw_instr = (bus.instr_i[31:30] == 2'b00) && (bus.instr_i[29:28] == 2'b10);
  assign bp_hit   = bus.bp_en_i && (bus.pc_i == bus.bp_addr_i) && !bp_skip_q;
  assign unused_instr_bits = ^bus.instr_i[27:0];

`ifdef COBRA_EXEC_CTRL_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  logic [WDT_W-1:0] wdt_cnt_q;
  logic             wdt_d, wdt_q;
`endif

  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    bp_skip_d   = bp_skip_q;
    commit      = 1'b0;
    ack         = 1'b0;
`ifdef COBRA_EXEC_CTRL_WDT_EN
    wdt_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.run_i)       state_d = RUN;
        else if (bus.step_i) state_d = STEP;
      end
      RUN, STEP: begin
        if (bus.halt_i) begin
          state_d = IDLE;
        end else if (bp_hit) begin
          state_d = BREAK;
        end else if (sw_instr && !bus.sw_valid_i) begin
          state_d     = WAIT_SW;
          step_mode_d = (state_q == STEP);
        end else begin
          commit    = 1'b1;
          ack       = sw_instr;
          bp_skip_d = 1'b0;
          state_d   = (state_q == STEP) ? IDLE : RUN;
        end
      end
      WAIT_SW: begin
        if (bus.halt_i) begin
          state_d = IDLE;
        end else if (bus.sw_valid_i) begin
          commit    = 1'b1;
          ack       = 1'b1;
          bp_skip_d = 1'b0;
          state_d   = step_mode_q ? IDLE : RUN;
        end else begin
`ifdef COBRA_EXEC_CTRL_WDT_EN
          if (wdt_cnt_q == WDT_LAST) begin
            state_d = IDLE;
            wdt_d   = 1'b1;
          end
`endif
        end
      end
      BREAK: begin
        // bp_skip lets the breakpointed instruction retire once on resume
        if (bus.halt_i) begin
          state_d   = IDLE;
          bp_skip_d = 1'b0;
        end else if (bus.run_i) begin
          state_d   = RUN;
          bp_skip_d = 1'b1;
        end else if (bus.step_i) begin
          state_d   = STEP;
          bp_skip_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, commit};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      step_mode_q <= 1'b0;
      bp_skip_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      bp_skip_q   <= bp_skip_d;
      retired_q   <= retired_d;
    end
  end

`ifdef COBRA_EXEC_CTRL_WDT_EN
  // Count stalled cycles only while waiting; any other state re-arms the counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdt_cnt_q <= '0;
      wdt_q     <= 1'b0;
    end else begin
      wdt_q <= wdt_d;
      if (state_q != WAIT_SW)      wdt_cnt_q <= '0;
      else if (!bus.sw_valid_i)    wdt_cnt_q <= wdt_cnt_q + 1'b1;
    end
  end
  assign bus.wdt_o = wdt_q;
`else
  assign bus.wdt_o = 1'b0;
`endif

  // The core commits on the same edge, so a reset edge must suppress the commit
  assign bus.core_en_o = commit && !rst_i;
  assign bus.sw_ack_o  = ack && !rst_i;
  assign bus.state_o   = state_q;
  assign bus.halted_o  = (state_q == IDLE) || (state_q == BREAK);
  assign bus.retired_o = retired_q;

endmodule

// File: tb/tb_cobra_exec_ctrl.sv
// Directed bench for cobra_exec_ctrl: run, step, breakpoint, switch wait, reset, counter wrap.
// Watchdog vectors are included when COBRA_EXEC_CTRL_WDT_EN is defined.
module tb_cobra_exec_ctrl;
  localparam int CNT_W = 4;
  localparam logic [31:0] I_NOP = 32'h0000_0000;
  localparam logic [31:0] I_SW  = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [CNT_W-1:0] exp_ret;

  cobra_exec_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cobra_exec_ctrl #(.CNT_W(CNT_W), .WDT_CYCLES(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    bus.run_i = 1'b1;
    #1 check_eq("no_commit_on_start", bus.core_en_o, 0);
    tick();
    bus.run_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.run_i = 0; bus.halt_i = 0; bus.step_i = 0; bus.bp_en_i = 0;
    bus.bp_addr_i = 0; bus.pc_i = 0; bus.instr_i = I_NOP; bus.sw_valid_i = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("rst_state", bus.state_o, 0);
    check_eq("rst_retired", bus.retired_o, 0);
    check_eq("rst_core_en", bus.core_en_o, 0);
    check_eq("rst_sw_ack", bus.sw_ack_o, 0);
    check_eq("rst_halted", bus.halted_o, 1);
    check_eq("rst_wdt", bus.wdt_o, 0);
    exp_ret = 0;

    // 1: free run of five plain instructions
    pulse_run();
    for (int i = 0; i < 5; i++) begin
      check_eq("run_core_en", bus.core_en_o, 1);
      check_eq("run_state", bus.state_o, 1);
      tick();
      exp_ret++;
    end
    bus.halt_i = 1'b1;
    #1 check_eq("halt_no_commit", bus.core_en_o, 0);
    tick();
    bus.halt_i = 1'b0;
    check_eq("halt_state", bus.state_o, 0);
    check_eq("run_retired", bus.retired_o, exp_ret);

    // 2: single step
    bus.step_i = 1'b1;
    #1 check_eq("step_req_no_commit", bus.core_en_o, 0);
    tick();
    bus.step_i = 1'b0;
    #1;
    check_eq("step_state", bus.state_o, 2);
    check_eq("step_core_en", bus.core_en_o, 1);
    tick(); exp_ret++;
    check_eq("step_back_idle", bus.state_o, 0);
    check_eq("step_core_en_off", bus.core_en_o, 0);
    check_eq("step_retired", bus.retired_o, exp_ret);

    // 3: breakpoint at PC 8, resume, re-hit after leaving
    bus.bp_en_i = 1'b1; bus.bp_addr_i = 32'h8; bus.pc_i = 0;
    pulse_run();
    for (int i = 0; i < 2; i++) begin
      #1 check_eq("bp_pre_commit", bus.core_en_o, 1);
      tick(); exp_ret++;
      bus.pc_i = bus.pc_i + 4;
    end
    #1 check_eq("bp_hit_no_commit", bus.core_en_o, 0);
    tick();
    check_eq("bp_state", bus.state_o, 4);
    check_eq("bp_halted", bus.halted_o, 1);
    check_eq("bp_hold", bus.core_en_o, 0);
    pulse_run();
    #1 check_eq("bp_resume_commit", bus.core_en_o, 1);
    tick(); exp_ret++;
    bus.pc_i = 32'hC;
    #1 check_eq("bp_after_commit", bus.core_en_o, 1);
    tick(); exp_ret++;
    bus.pc_i = 32'h8;
    #1 check_eq("bp_rehit", bus.core_en_o, 0);
    tick();
    check_eq("bp_rehit_state", bus.state_o, 4);
    check_eq("bp_retired", bus.retired_o, exp_ret);

    // 5a: halt beats run in BREAK
    bus.halt_i = 1'b1; bus.run_i = 1'b1;
    tick();
    bus.halt_i = 1'b0; bus.run_i = 1'b0;
    check_eq("halt_over_run", bus.state_o, 0);
    bus.bp_en_i = 1'b0;

    // 4: switch wait, three stalled cycles then a committed value
    bus.instr_i = I_SW; bus.sw_valid_i = 1'b0;
    pulse_run();
    #1 check_eq("sw_stall_no_commit", bus.core_en_o, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("sw_wait_state", bus.state_o, 3);
      check_eq("sw_wait_no_commit", bus.core_en_o, 0);
      tick();
    end
    bus.sw_valid_i = 1'b1;
    #1;
    check_eq("sw_commit", bus.core_en_o, 1);
    check_eq("sw_ack", bus.sw_ack_o, 1);
    tick(); exp_ret++;
    bus.sw_valid_i = 1'b0;
    check_eq("sw_back_run", bus.state_o, 1);
    check_eq("sw_retired", bus.retired_o, exp_ret);
    tick();
    check_eq("sw_wait_again", bus.state_o, 3);

    // 5b: reset in WAIT_SW suppresses the commit and clears everything
    rst = 1'b1; bus.sw_valid_i = 1'b1;
    #1;
    check_eq("rst_edge_no_commit", bus.core_en_o, 0);
    check_eq("rst_edge_no_ack", bus.sw_ack_o, 0);
    tick();
    rst = 1'b0; bus.sw_valid_i = 1'b0;
    #1;
    check_eq("midrst_state", bus.state_o, 0);
    check_eq("midrst_retired", bus.retired_o, 0);
    check_eq("midrst_halted", bus.halted_o, 1);
    exp_ret = 0;

    // Step into a switch wait: commit returns to IDLE
    bus.step_i = 1'b1;
    tick();
    bus.step_i = 1'b0;
    #1 check_eq("stepsw_stall", bus.core_en_o, 0);
    tick();
    check_eq("stepsw_wait", bus.state_o, 3);
    bus.sw_valid_i = 1'b1;
    #1 check_eq("stepsw_ack", bus.sw_ack_o, 1);
    tick(); exp_ret++;
    bus.sw_valid_i = 1'b0;
    check_eq("stepsw_idle", bus.state_o, 0);
    check_eq("stepsw_retired", bus.retired_o, exp_ret);

    // Counter wrap: 15 more commits take a 4-bit count from 1 to 0
    bus.instr_i = I_NOP;
    pulse_run();
    for (int i = 0; i < 15; i++) tick();
    bus.halt_i = 1'b1;
    tick();
    bus.halt_i = 1'b0;
    check_eq("wrap_retired", bus.retired_o, 0);
    exp_ret = 0;

`ifdef COBRA_EXEC_CTRL_WDT_EN
    // 6: watchdog fires on the fourth stalled cycle
    bus.instr_i = I_SW; bus.sw_valid_i = 1'b0;
    pulse_run();
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("wdt_wait_state", bus.state_o, 3);
      check_eq("wdt_quiet", bus.wdt_o, 0);
      tick();
    end
    check_eq("wdt_state", bus.state_o, 0);
    check_eq("wdt_pulse", bus.wdt_o, 1);
    check_eq("wdt_retired", bus.retired_o, exp_ret);
    tick();
    check_eq("wdt_pulse_end", bus.wdt_o, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
